// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types and constants for the GRF writeback arbiter and its secondary FIFO.
package grf_wb_arbiter_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // One pending register-file write: destination, value and the pc tag of its instruction.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } wb_rec_t;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Circular queue of secondary writebacks with per-entry valid bits.
// A primary write can kill queued entries by address. Killed entries
// still occupy their slot until they reach the head, where they are
// silently dropped. Two associative ports report live entries matching
// a lookup address.
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_rec_t                  push_rec,
  input  logic                     issue,
  input  logic                     kill_en,
  input  logic [AW-1:0]            kill_addr,
  input  logic [AW-1:0]            look_a1,
  input  logic [AW-1:0]            look_a2,
  output logic                     head_valid,
  output wb_rec_t                  head_rec,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hit1,
  output logic                     hit2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_rec_t          mem_q [DEPTH];
  wb_rec_t          mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_empty;
  logic             pop;

  // Head status: a killed head is popped on its own, a live head only when the arbiter takes it.
  always_comb begin
    not_empty  = (count_q != '0);
    head_valid = not_empty && valid_q[rd_ptr_q];
    head_rec   = mem_q[rd_ptr_q];
    pop        = not_empty && (!valid_q[rd_ptr_q] || issue);
    full       = (count_q == CW'(DEPTH));
    count      = count_q;
  end

  // Associative lookups over live entries only; an entry pushed this cycle is not visible yet.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].addr == look_a1)) hit1 = 1'b1;
      if (valid_q[i] && (mem_q[i].addr == look_a2)) hit2 = 1'b1;
    end
  end

  // Next-state: kill matching entries, retire the head, then append the new record.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (mem_q[i].addr == kill_addr)) valid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q]   = push_rec;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Control state; reset empties the queue and drops every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; entries are meaningless until their valid bit is set.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Write-side front end of the GRF: merges the in-order W-stage write and
// the queued multi-cycle unit results onto the single GRF write port, and
// reports queued or in-flight writes for hazard detection.
// AW/DW must match the package widths used by the writeback record.
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pri_we,
  input  logic [AW-1:0]          pri_addr,
  input  logic [DW-1:0]          pri_data,
  input  logic [DW-1:0]          pri_pc,
  input  logic                   sec_valid,
  output logic                   sec_ready,
  input  logic [AW-1:0]          sec_addr,
  input  logic [DW-1:0]          sec_data,
  input  logic [DW-1:0]          sec_pc,
  output logic                   grf_we,
  output logic [AW-1:0]          grf_addr,
  output logic [DW-1:0]          grf_wd,
  output logic [DW-1:0]          grf_pc,
  input  logic [AW-1:0]          look_a1,
  input  logic [AW-1:0]          look_a2,
  output logic                   pend1,
  output logic                   pend2,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import grf_wb_arbiter_pkg::*;

  wb_rec_t       push_rec;
  wb_rec_t       head_rec;
  logic          head_valid;
  logic          fifo_full;
  logic          push;
  logic          pri_issue;
  logic          sec_issue;
  logic          hit1, hit2;

  logic          grf_we_q, grf_we_d;
  logic [AW-1:0] grf_addr_q, grf_addr_d;
  logic [DW-1:0] grf_wd_q, grf_wd_d;
  logic [DW-1:0] grf_pc_q, grf_pc_d;

  // Handshake and issue decisions; writes to r0 are swallowed on both sources.
  always_comb begin
    sec_ready     = !fifo_full && !reset;
    push          = sec_valid && sec_ready && (sec_addr != REG_ZERO);
    push_rec.addr = sec_addr;
    push_rec.data = sec_data;
    push_rec.pc   = sec_pc;
    pri_issue     = pri_we && (pri_addr != REG_ZERO);
    sec_issue     = !pri_issue && head_valid;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rec  (push_rec),
    .issue     (sec_issue),
    .kill_en   (pri_issue),
    .kill_addr (pri_addr),
    .look_a1   (look_a1),
    .look_a2   (look_a2),
    .head_valid(head_valid),
    .head_rec  (head_rec),
    .full      (fifo_full),
    .count     (fifo_count),
    .hit1      (hit1),
    .hit2      (hit2)
  );

  // Issue mux: the primary always wins, the FIFO head fills idle slots, otherwise hold the bus.
  always_comb begin
    grf_we_d   = 1'b0;
    grf_addr_d = grf_addr_q;
    grf_wd_d   = grf_wd_q;
    grf_pc_d   = grf_pc_q;
    if (pri_issue) begin
      grf_we_d   = 1'b1;
      grf_addr_d = pri_addr;
      grf_wd_d   = pri_data;
      grf_pc_d   = pri_pc;
    end else if (sec_issue) begin
      grf_we_d   = 1'b1;
      grf_addr_d = head_rec.addr;
      grf_wd_d   = head_rec.data;
      grf_pc_d   = head_rec.pc;
    end
  end

  // Registered GRF write port; reset discards any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we_q   <= 1'b0;
      grf_addr_q <= '0;
      grf_wd_q   <= '0;
      grf_pc_q   <= '0;
    end else begin
      grf_we_q   <= grf_we_d;
      grf_addr_q <= grf_addr_d;
      grf_wd_q   <= grf_wd_d;
      grf_pc_q   <= grf_pc_d;
    end
  end

  // Hazard view: a register is pending while queued live or being written this cycle.
  always_comb begin
    grf_we    = grf_we_q;
    grf_addr  = grf_addr_q;
    grf_wd    = grf_wd_q;
    grf_pc    = grf_pc_q;
    pend1     = (look_a1 != REG_ZERO) && (hit1 || (grf_we_q && (grf_addr_q == look_a1)));
    pend2     = (look_a2 != REG_ZERO) && (hit2 || (grf_we_q && (grf_addr_q == look_a2)));
    stall_req = fifo_full;
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: a per-cycle vector table for the basic
// paths (reset, primary, secondary, r0, kill) and hand-written sequences for
// backpressure/drain and mid-operation reset.
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pri_we;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data, pri_pc;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data, sec_pc;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd, grf_pc;
  logic [4:0]  look_a1, look_a2;
  logic        pend1, pend2;
  logic        stall_req;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        pri_we;
    logic [4:0]  pri_addr;
    logic [31:0] pri_data;
    logic [31:0] pri_pc;
    logic        sec_valid;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data;
    logic [31:0] sec_pc;
    logic [4:0]  look_a1;
    logic [4:0]  look_a2;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
    logic        exp_ready;
    logic        exp_stall;
    logic        exp_p1;
    logic        exp_p2;
  } vec_t;

  vec_t vecs [13];

  grf_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .pri_we    (pri_we),
    .pri_addr  (pri_addr),
    .pri_data  (pri_data),
    .pri_pc    (pri_pc),
    .sec_valid (sec_valid),
    .sec_ready (sec_ready),
    .sec_addr  (sec_addr),
    .sec_data  (sec_data),
    .sec_pc    (sec_pc),
    .grf_we    (grf_we),
    .grf_addr  (grf_addr),
    .grf_wd    (grf_wd),
    .grf_pc    (grf_pc),
    .look_a1   (look_a1),
    .look_a2   (look_a2),
    .pend1     (pend1),
    .pend2     (pend2),
    .stall_req (stall_req),
    .fifo_count(fifo_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset     = v.rst;
    pri_we    = v.pri_we;
    pri_addr  = v.pri_addr;
    pri_data  = v.pri_data;
    pri_pc    = v.pri_pc;
    sec_valid = v.sec_valid;
    sec_addr  = v.sec_addr;
    sec_data  = v.sec_data;
    sec_pc    = v.sec_pc;
    look_a1   = v.look_a1;
    look_a2   = v.look_a2;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("v%0d grf_we", idx),     64'(grf_we),     64'(v.exp_we));
    check($sformatf("v%0d grf_addr", idx),   64'(grf_addr),   64'(v.exp_addr));
    check($sformatf("v%0d grf_wd", idx),     64'(grf_wd),     64'(v.exp_wd));
    check($sformatf("v%0d grf_pc", idx),     64'(grf_pc),     64'(v.exp_pc));
    check($sformatf("v%0d fifo_count", idx), 64'(fifo_count), 64'(v.exp_count));
    check($sformatf("v%0d sec_ready", idx),  64'(sec_ready),  64'(v.exp_ready));
    check($sformatf("v%0d stall_req", idx),  64'(stall_req),  64'(v.exp_stall));
    check($sformatf("v%0d pend1", idx),      64'(pend1),      64'(v.exp_p1));
    check($sformatf("v%0d pend2", idx),      64'(pend2),      64'(v.exp_p2));
  endtask

  task automatic drive_idle();
    pri_we    = 1'b0;
    pri_addr  = 5'd0;
    pri_data  = 32'h0;
    pri_pc    = 32'h0;
    sec_valid = 1'b0;
    sec_addr  = 5'd0;
    sec_data  = 32'h0;
    sec_pc    = 32'h0;
    look_a1   = 5'd0;
    look_a2   = 5'd0;
  endtask

  task automatic drive_pri(input int a);
    pri_we   = 1'b1;
    pri_addr = 5'(a);
    pri_data = 32'h0C00 + 32'(a);
    pri_pc   = 32'h3000 + 32'(a) * 4;
  endtask

  task automatic drive_sec(input int a);
    sec_valid = 1'b1;
    sec_addr  = 5'(a);
    sec_data  = 32'h0B00 + 32'(a);
    sec_pc    = 32'h7000 + 32'(a) * 4;
  endtask

  // Primary busy every cycle while five secondaries arrive; then drain in order.
  task automatic run_backpressure();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_pri(20 + c);
      drive_sec(10 + c);
      check($sformatf("bp accept%0d sec_ready", c), 64'(sec_ready), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    drive_pri(24);
    drive_sec(14);
    check("bp full fifo_count", 64'(fifo_count), 64'd4);
    check("bp full stall_req",  64'(stall_req),  64'd1);
    check("bp full sec_ready",  64'(sec_ready),  64'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp held fifo_count", 64'(fifo_count), 64'd4);
    check("bp held grf_addr",   64'(grf_addr),   64'd24);
    check("bp held grf_we",     64'(grf_we),     64'd1);
    drive_idle();
    look_a1 = 5'd13;
    #1;
    check("bp pend1 queued 13", 64'(pend1), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp drain10 grf_we",     64'(grf_we),     64'd1);
    check("bp drain10 grf_addr",   64'(grf_addr),   64'd10);
    check("bp drain10 grf_wd",     64'(grf_wd),     64'h0B0A);
    check("bp drain10 fifo_count", 64'(fifo_count), 64'd3);
    check("bp drain10 sec_ready",  64'(sec_ready),  64'd1);
    drive_sec(14);
    @(posedge clk);
    @(negedge clk);
    check("bp drain11 grf_addr",   64'(grf_addr),   64'd11);
    check("bp push+pop fifo_count", 64'(fifo_count), 64'd3);
    drive_idle();
    for (int j = 12; j <= 14; j++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp drain%0d grf_we", j),     64'(grf_we),     64'd1);
      check($sformatf("bp drain%0d grf_addr", j),   64'(grf_addr),   64'(j));
      check($sformatf("bp drain%0d grf_wd", j),     64'(grf_wd),     64'(32'h0B00 + 32'(j)));
      check($sformatf("bp drain%0d grf_pc", j),     64'(grf_pc),     64'(32'h7000 + 32'(j) * 4));
      check($sformatf("bp drain%0d fifo_count", j), 64'(fifo_count), 64'(14 - j));
    end
    @(posedge clk);
    @(negedge clk);
    check("bp empty grf_we", 64'(grf_we), 64'd0);
  endtask

  // Three queued entries plus a primary write in flight, then a one-cycle reset.
  task automatic run_mid_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_pri(25 + c);
      drive_sec(16 + c);
      @(posedge clk);
    end
    @(negedge clk);
    check("rst pre fifo_count", 64'(fifo_count), 64'd3);
    reset = 1'b1;
    drive_pri(28);
    drive_sec(19);
    @(posedge clk);
    @(negedge clk);
    check("rst fifo_count", 64'(fifo_count), 64'd0);
    check("rst grf_we",     64'(grf_we),     64'd0);
    check("rst grf_addr",   64'(grf_addr),   64'd0);
    check("rst sec_ready",  64'(sec_ready),  64'd0);
    reset = 1'b0;
    drive_idle();
    #1;
    check("post rst sec_ready", 64'(sec_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("post rst%0d grf_we", c),     64'(grf_we),     64'd0);
      check($sformatf("post rst%0d fifo_count", c), 64'(fifo_count), 64'd0);
    end
  endtask

  // Main sequence: vector table first, then the multi-cycle corner cases.
  initial begin
    reset = 1'b1;
    drive_idle();

    vecs[0]  = '{1,0,0,0,0,            0,0,0,0,            0,0, 0,0,0,0,                0,0,0,0,0};
    vecs[1]  = '{0,0,0,0,0,            0,0,0,0,            0,0, 0,0,0,0,                0,1,0,0,0};
    vecs[2]  = '{0,1,5,'h1234,'h3004,  0,0,0,0,            5,0, 1,5,'h1234,'h3004,      0,1,0,1,0};
    vecs[3]  = '{0,0,0,0,0,            0,0,0,0,            5,0, 0,5,'h1234,'h3004,      0,1,0,0,0};
    vecs[4]  = '{0,0,0,0,0,            1,8,'hA,'h4000,     8,0, 0,5,'h1234,'h3004,      1,1,0,1,0};
    vecs[5]  = '{0,0,0,0,0,            0,0,0,0,            8,5, 1,8,'hA,'h4000,         0,1,0,1,0};
    vecs[6]  = '{0,0,0,0,0,            0,0,0,0,            8,0, 0,8,'hA,'h4000,         0,1,0,0,0};
    vecs[7]  = '{0,1,0,'h66,'h5004,    1,0,'h77,'h5000,    0,0, 0,8,'hA,'h4000,         0,1,0,0,0};
    vecs[8]  = '{0,0,0,0,0,            0,0,0,0,            0,0, 0,8,'hA,'h4000,         0,1,0,0,0};
    vecs[9]  = '{0,0,0,0,0,            1,9,'h1,'h6000,     9,0, 0,8,'hA,'h4000,         1,1,0,1,0};
    vecs[10] = '{0,1,9,'h2,'h6004,     0,0,0,0,            9,0, 1,9,'h2,'h6004,         1,1,0,1,0};
    vecs[11] = '{0,0,0,0,0,            0,0,0,0,            9,0, 0,9,'h2,'h6004,         0,1,0,0,0};
    vecs[12] = '{0,0,0,0,0,            0,0,0,0,            9,0, 0,9,'h2,'h6004,         0,1,0,0,0};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      @(posedge clk);
      #1;
      check_output(vecs[i], i);
    end

    @(negedge clk);
    drive_idle();
    run_backpressure();
    run_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Write-side front end for the general register file (GRF).
- Merges two writeback sources into the GRF's single write port, one write per cycle:
  - the primary in-order pipeline W-stage;
  - a secondary, late-completing multi-cycle unit (mult/div result path), connected through a valid/ready handshake and a small FIFO.
- Drives the GRF write address, write data, write enable and pc from registered outputs.
- Reports pending (queued or in-flight) writes so hazard logic can stall readers.

Parameters:
- DEPTH, 4, secondary FIFO entries; power of 2, minimum 2.
- AW, 5, register address width.
- DW, 32, data and pc width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pri_we  in  1  primary write request; no handshake, always accepted
- pri_addr  in  AW  primary destination register
- pri_data  in  DW  primary write data
- pri_pc  in  DW  pc tag of the primary instruction
- sec_valid  in  1  secondary result valid
- sec_ready  out  1  secondary result accepted this cycle
- sec_addr  in  AW  secondary destination register
- sec_data  in  DW  secondary write data
- sec_pc  in  DW  pc tag of the secondary instruction
- grf_we  out  1  GRF write enable (registered)
- grf_addr  out  AW  GRF write address, GRF A3 (registered)
- grf_wd  out  DW  GRF write data, GRF WD (registered)
- grf_pc  out  DW  pc forwarded to the GRF write trace (registered)
- look_a1  in  AW  hazard lookup address 1
- look_a2  in  AW  hazard lookup address 2
- pend1  out  1  a write to look_a1 is queued or in flight
- pend2  out  1  a write to look_a2 is queued or in flight
- stall_req  out  1  FIFO full; the pipeline must hold
- fifo_count  out  $clog2(DEPTH)+1  number of valid queued entries

Behaviour:
- Reset: FIFO emptied, all entries invalid; grf_we, grf_addr, grf_wd, grf_pc all 0; fifo_count 0; stall_req 0.
- sec_ready = !full && !reset. A handshake occurs when sec_valid && sec_ready.
- Writes to register 0:
  - primary with pri_addr==0: ignored;
  - secondary with sec_addr==0: handshake completes, nothing is enqueued.
- Issue selection, evaluated every cycle; the result is registered onto the grf_* outputs at the next edge:
  1. pri_we && pri_addr!=0 issues the primary write.
  2. Otherwise, if the FIFO head is valid, the head issues and is popped.
  3. Otherwise grf_we <= 0; grf_addr, grf_wd and grf_pc hold their previous values.
- Latency:
  - primary: 1 cycle from request to grf_we;
  - secondary: enqueue on the handshake edge, earliest issue on the following edge, so 2 cycles minimum.
  - There is no FIFO bypass.
- FIFO:
  - circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a per-entry valid bit;
  - enqueue and pop in the same cycle are allowed, and count is unchanged;
  - full is defined as count==DEPTH; sec_ready=0 while full, so there is no same-cycle pass-through when full.
- Kill rule (ordering):
  - the primary write is always the younger instruction;
  - when a primary write to X issues, every valid FIFO entry with addr==X has its valid bit cleared in the same edge;
  - a killed entry is popped without issuing a write when it reaches the head, and popping a killed head takes no issue slot.
- pend lookups, combinational:
  - pendN = (look_aN!=0) && (any valid FIFO entry with addr==look_aN, or grf_we && grf_addr==look_aN);
  - an entry being enqueued in the current cycle is not yet visible.
- stall_req = full.
  - It is only a request; this block never drops a primary write.
- Reset asserted mid-operation: queued and in-flight writes are discarded; no GRF write occurs on the reset edge.

Decomposition:
- Shared package holds:
  - AW and DW constants;
  - REG_ZERO = 5'd0;
  - the writeback record typedef {addr, data, pc}, used by the FIFO and both source ports.
- One sub-module: wb_fifo. It contains the circular buffer, valid bits, kill-by-address input, count, and associative lookup ports. The arbiter top holds the issue mux and the output registers.

Test Plan:
- Reset, then pri_we=1, pri_addr=5, pri_data=32'h1234, pri_pc=32'h3004 → next edge grf_we=1, grf_addr=5, grf_wd=32'h1234, grf_pc=32'h3004; the edge after that, grf_we=0.
- Idle pipeline; sec_valid=1 with addr=8, data=32'hA for one cycle → sec_ready=1, fifo_count=1, pend for look_a1=8 is 1; one edge later grf_we=1, grf_addr=8; fifo_count=0.
- Primary busy every cycle; sec_valid held high with 5 distinct addresses → 4 accepted, then sec_ready=0 and stall_req=1; release the primary → FIFO drains in order, one write per cycle, and sec_ready returns.
- Enqueue a secondary write to 9 (data 32'h1), then a primary write to 9 (data 32'h2) while it is queued → exactly one GRF write to 9, with data 32'h2; the killed entry produces no write; fifo_count returns to 0.
- Secondary write to addr 0, and primary write to addr 0 → handshake completes; no grf_we; pend1 with look_a1=0 is 0.
- Fill the FIFO with 3 entries, assert reset for 1 cycle → fifo_count=0, grf_we=0, no writes after reset; sec_ready=1 on the first cycle after reset.
